// File: rtl/text_scanner_pkg.sv
// Shared constants and FSM state type for the text-mode scanner and its text RAM.
package text_scanner_pkg;

  localparam int CHARINDEX_W       = 7;   // character index, 6:0
  localparam int CHARWIDTH_W       = 3;   // glyph column, 2:0
  localparam int CHARHEIGHT_W      = 4;   // glyph line, 3:0
  localparam int CHARHEIGHT_PIXELS = 10;
  localparam int TEXTADDR_W        = 10;  // cell address, 9:0

  typedef enum logic {
    FSM_CLEAR,
    FSM_IDLE
  } fsm_state_t;

endpackage

// File: rtl/text_ram.sv
// Simple dual-port text RAM: one write port, one registered read port (read-first).
module text_ram #(
  parameter int DEPTH = 1000,
  parameter int WIDTH = 7,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read and write share the edge, so a same-cell access returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_scanner.sv
// Text-mode raster walker feeding character_generator; owns the text RAM and its clear FSM.
// Optional blinking block cursor when TEXT_CURSOR_EN is defined.
module text_scanner
  import text_scanner_pkg::*;
#(
  parameter int                     COLUMNS    = 40,
  parameter int                     ROWS       = 25,
  parameter int                     HREP       = 2,
  parameter int                     VREP       = 2,
  parameter logic [CHARINDEX_W-1:0] BLANK_CHAR = 7'h20
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    frame_start,
  input  logic                    line_start,
  input  logic                    active,
  input  logic                    clear,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [TEXTADDR_W-1:0]   wr_addr,
  input  logic [CHARINDEX_W-1:0]  wr_data,
`ifdef TEXT_CURSOR_EN
  input  logic [TEXTADDR_W-1:0]   cursor_addr,
`endif
  output logic [CHARWIDTH_W-1:0]  xchar,
  output logic [CHARHEIGHT_W-1:0] ychar,
  output logic [CHARINDEX_W-1:0]  character_index,
  output logic                    pixel_valid
);

  localparam int CELLS  = COLUMNS * ROWS;
  localparam int COL_W  = $clog2(COLUMNS + 1);
  localparam int ROW_W  = $clog2(ROWS + 1);
  localparam int HREP_W = (HREP > 1) ? $clog2(HREP) : 1;
  localparam int VREP_W = (VREP > 1) ? $clog2(VREP) : 1;

  logic [HREP_W-1:0]       hrep;
  logic [VREP_W-1:0]       vrep;
  logic [CHARWIDTH_W-1:0]  xcnt;
  logic [CHARHEIGHT_W-1:0] ycnt;
  logic [COL_W-1:0]        col;
  logic [ROW_W-1:0]        row;
  logic                    first_line, frame_ok;

  logic                    in_area, in_s1;
  logic [CHARHEIGHT_W-1:0] ychar_s1;
  logic [TEXTADDR_W-1:0]   rd_addr;
  logic [CHARINDEX_W-1:0]  ram_q, char_next;

  fsm_state_t              state, state_next;
  logic [TEXTADDR_W-1:0]   clr_addr, clr_addr_next;
  logic                    ram_we;
  logic [TEXTADDR_W-1:0]   ram_waddr;
  logic [CHARINDEX_W-1:0]  ram_wdata;

  // frame_ok keeps the display blank after a mid-frame reset until the next frame_start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hrep       <= '0;
      xcnt       <= '0;
      col        <= '0;
      vrep       <= '0;
      ycnt       <= '0;
      row        <= '0;
      first_line <= 1'b1;
      frame_ok   <= 1'b0;
    end else begin
      if (frame_start) begin
        vrep       <= '0;
        ycnt       <= '0;
        row        <= '0;
        first_line <= 1'b1;
        frame_ok   <= 1'b1;
      end else if (line_start) begin
        first_line <= 1'b0;
        if (!first_line) begin
          if (vrep == VREP_W'(VREP - 1)) begin
            vrep <= '0;
            if (ycnt == CHARHEIGHT_W'(CHARHEIGHT_PIXELS - 1)) begin
              ycnt <= '0;
              if (row != ROW_W'(ROWS)) row <= row + 1'b1;
            end else begin
              ycnt <= ycnt + 1'b1;
            end
          end else begin
            vrep <= vrep + 1'b1;
          end
        end
      end
      if (line_start) begin
        hrep <= '0;
        xcnt <= '0;
        col  <= '0;
      end else if (active) begin
        if (hrep == HREP_W'(HREP - 1)) begin
          hrep <= '0;
          xcnt <= xcnt + 1'b1;
          if (xcnt == '1 && col != COL_W'(COLUMNS)) col <= col + 1'b1;
        end else begin
          hrep <= hrep + 1'b1;
        end
      end
    end
  end

  assign in_area = active && frame_ok && (col < COL_W'(COLUMNS)) && (row < ROW_W'(ROWS));
  assign rd_addr = TEXTADDR_W'(row) * TEXTADDR_W'(COLUMNS) + TEXTADDR_W'(col);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= FSM_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
    end
  end

  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    wr_ready      = 1'b0;
    ram_we        = 1'b0;
    ram_waddr     = wr_addr;
    ram_wdata     = wr_data;
    case (state)
      FSM_CLEAR: begin
        if (clear) begin
          clr_addr_next = '0;
        end else begin
          ram_we    = 1'b1;
          ram_waddr = clr_addr;
          ram_wdata = BLANK_CHAR;
          if (clr_addr == TEXTADDR_W'(CELLS - 1)) begin
            state_next    = FSM_IDLE;
            clr_addr_next = '0;
          end else begin
            clr_addr_next = clr_addr + 1'b1;
          end
        end
      end
      FSM_IDLE: begin
        if (clear) begin
          state_next    = FSM_CLEAR;
          clr_addr_next = '0;
        end else begin
          wr_ready = 1'b1;
          ram_we   = wr_valid && (wr_addr < TEXTADDR_W'(CELLS));
        end
      end
      default: state_next = FSM_CLEAR;
    endcase
  end

  text_ram #(
    .DEPTH (CELLS),
    .WIDTH (CHARINDEX_W),
    .AW    (TEXTADDR_W)
  ) u_text_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

`ifdef TEXT_CURSOR_EN
  logic [5:0]            frame_cnt;
  logic [TEXTADDR_W-1:0] addr_s1;
  logic                  cursor_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      addr_s1   <= '0;
    end else begin
      if (frame_start) frame_cnt <= frame_cnt + 1'b1;
      addr_s1 <= rd_addr;
    end
  end

  assign cursor_hit = frame_cnt[5] && in_s1 && (addr_s1 == cursor_addr) &&
                      (ychar_s1 >= CHARHEIGHT_W'(CHARHEIGHT_PIXELS - 2));

  always_comb begin
    char_next = ram_q;
    if (cursor_hit) char_next = '1;
  end
`else
  always_comb begin
    char_next = ram_q;
  end
`endif

  // Stage 1 lines up with the RAM read; stage 2 drives the outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xchar           <= '0;
      in_s1           <= 1'b0;
      ychar_s1        <= '0;
      ychar           <= '0;
      character_index <= BLANK_CHAR;
      pixel_valid     <= 1'b0;
    end else begin
      xchar           <= xcnt;
      in_s1           <= in_area;
      ychar_s1        <= ycnt;
      pixel_valid     <= in_s1;
      ychar           <= in_s1 ? ychar_s1 : '0;
      character_index <= in_s1 ? char_next : BLANK_CHAR;
    end
  end

endmodule

// File: doc/text_scanner.md
# text_scanner

Upstream feeder for `character_generator`: walks the text-mode screen in step with the VGA raster and owns the text RAM (`COLUMNS` × `ROWS` character indices). It emits `xchar`, `ychar` and `character_index` with the skew that `character_generator` needs, so its `pixel` output is valid at a fixed latency. A valid/ready write port fills the text RAM, and an internal FSM clears the screen.

## Interface
- `COLUMNS`, 40: text columns.
- `ROWS`, 25: text rows.
- `HREP`, 2: horizontal pixel repeat (1 or 2).
- `VREP`, 2: vertical line repeat (1 or 2).
- `BLANK_CHAR`, 7'h20: index written by clear.
- `clk`  in  1  pixel clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `frame_start`  in  1  one-cycle pulse before the first active line.
- `line_start`  in  1  one-cycle pulse before the first active pixel of each line.
- `active`  in  1  active-video pixel strobe.
- `clear`  in  1  pulse; starts a screen clear.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  write accepted when both `wr_valid` and `wr_ready` are high.
- `wr_addr`  in  10  cell address, row*COLUMNS+col.
- `wr_data`  in  `CHARINDEX_RANGE`  character index.
- `cursor_addr`  in  10  cursor cell; present only with `TEXT_CURSOR_EN`.
- `xchar`  out  `CHARWIDTH_RANGE`  column pixel, one cycle early.
- `ychar`  out  `CHARHEIGHT_RANGE`  row line.
- `character_index`  out  `CHARINDEX_RANGE`  glyph index.
- `pixel_valid`  out  1  the pixel from `character_generator` is inside the text area this cycle.

## Operation
- **Raster counters:**
  - `frame_start` zeroes `row`, `ychar` and `vrep`.
  - `line_start` zeroes `col`, `xchar` and `hrep`.
  - Each `active` cycle advances `hrep`. When `hrep` wraps at `HREP`, `xchar` advances. When `xchar` wraps at 8, `col` advances and saturates at `COLUMNS`.
  - Each `line_start` after the first line of the frame advances `vrep`. When `vrep` wraps at `VREP`, `ychar` advances. When `ychar` wraps at `CHARHEIGHT_PIXELS`, `row` advances and saturates at `ROWS`.
- **In-area test:** a pixel is in the text area when `active && col<COLUMNS && row<ROWS`. Outside the area, `pixel_valid`=0, `character_index`=`BLANK_CHAR`, `ychar`=0.
- **Read address:** row*COLUMNS+col, computed in 10 bits (max 999).
- **Text RAM:** simple dual-port, 1 write port and 1 read port, registered read. A same-cycle write and read of the same cell is read-first: the old data is returned.
- **FSM states:** `CLEAR`, `IDLE`.
  - `CLEAR`: `wr_ready`=0. Writes `BLANK_CHAR` to addresses 0..COLUMNS*ROWS-1, one per cycle, then goes to `IDLE`.
  - `IDLE`: `wr_ready`=1. An accepted write with `wr_addr`≥COLUMNS*ROWS completes the handshake but is dropped.
  - `clear` in `IDLE` enters `CLEAR` at address 0.
  - `clear` during `CLEAR` restarts the clear from address 0.
  - `clear` and `wr_valid` in the same cycle: `clear` wins and the write is not accepted.
- Reset enters `CLEAR`. Display reads continue during a clear and show partial contents.

## Timing
- **Reset values:**
  - `xchar`=0, `ychar`=0, `character_index`=`BLANK_CHAR`, `pixel_valid`=0, `wr_ready`=0.
  - All counters are 0.
  - FSM is in `CLEAR` at address 0.
- **Latency:** for a pixel presented with `active` at cycle t:
  - `xchar` is valid at t+1.
  - `ychar`, `character_index` and `pixel_valid` are valid at t+2.
  - The `character_generator` registers its mask from `xchar`, so its `pixel` output is valid at t+2, aligned with `pixel_valid`.
- **Clear duration:** exactly COLUMNS*ROWS cycles; `wr_ready` rises the cycle after the last cell is written.
- **Write visibility:** an accepted write is visible to a read issued 1 cycle later.
- **Mid-frame reset:** output stays blank (`pixel_valid`=0) until the next `frame_start`.

## Configuration
- `TEXT_CURSOR_EN` defined:
  - Adds the `cursor_addr` port.
  - Adds a 6-bit frame counter, incremented on `frame_start`; blink phase is bit 5 (32 frames on, 32 off).
  - While the phase is high, the in-area read address equals `cursor_addr`, and `ychar`≥CHARHEIGHT_PIXELS-2, `character_index` is forced to 7'h7F.
  - The substitution is applied at the stage-2 output; latency is unchanged.
- `TEXT_CURSOR_EN` undefined: no cursor port, no frame counter, and no substitution logic.

## Structure
- **Shared constants** go in `constant.vh`: existing `CHAR*_RANGE` and `CHARHEIGHT_PIXELS`, plus new `TEXTADDR_RANGE` (9:0), `FSM_CLEAR`, `FSM_IDLE`.
- **Sub-module `text_ram`:** parameterised depth and width, write port plus registered read-first read port. It is instantiated once.
- Counters, FSM and output pipeline stay in `text_scanner`.

## Test plan
- **Reset and clear:** release `reset_n` → `wr_ready`=0 for exactly 1000 cycles. After that, reading every cell gives `character_index`=7'h20.
- **Write then display:** write 7'h41 at address 41 (row 1, col 1), HREP=VREP=2. On line 20, active pixels 16..31 → `character_index`=7'h41 with `pixel_valid`=1 at t+2. `xchar` steps 0,0,1,1,…,7,7, valid at t+1.
- **Out-of-area:** row counter at 25 (screen lines ≥500, VREP=2), or col≥40 → `pixel_valid`=0 and `character_index`=7'h20.
- **Invalid write:** write to `wr_addr`=1000 → handshake completes in 1 cycle; no cell changes.
- **Clear restart and clear/write collision:**
  - `clear` pulse at clear address 500 → the clear restarts at 0; `wr_ready` stays low for a further 1000 cycles.
  - `clear` and `wr_valid` in the same cycle → the write is not accepted.
- **Cursor (`TEXT_CURSOR_EN`):** `cursor_addr`=0 → in frames 32..63, `ychar`∈{8,9} of cell 0 gives 7'h7F. In frames 0..31 the stored index is shown.
